// File: rtl/alarm_sequencer.sv
// ============================================================================
// alarm_sequencer : alarm ring/snooze/dismiss sequencer for the alarm clock.
// Optional feature macro: ALARM_BUZZER_PULSE_EN (buzzer toggles every 500 ms).
// Revision: 1.0
// ============================================================================
`default_nettype none

module alarm_sequencer #(
  parameter int CLOCK_FREQ_1KHZ = 50000,
  parameter int SNOOZE_MIN      = 5,
  parameter int RING_TIMEOUT_S  = 60,
  parameter int MAX_SNOOZE      = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       armed,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       blink_en,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing
);

  localparam int PW = (CLOCK_FREQ_1KHZ > 1) ? $clog2(CLOCK_FREQ_1KHZ) : 1;
  localparam int SW = $clog2(RING_TIMEOUT_S + 1);
  localparam int CW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLOCK_FREQ_1KHZ - 1);
  localparam logic [SW-1:0] SEC_LAST = SW'(RING_TIMEOUT_S - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    tgt_hours_q, tgt_hours_d;
  logic [5:0]    tgt_min_q, tgt_min_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0]    ms_q, ms_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          alarm_match_q, alarm_edge_q;
  logic          snz_match_q, snz_edge_q;
  logic          ring_q, snz_q, buzzer_q, buzzer_d;

  logic       match_alarm, match_snooze, timeout;
  logic [6:0] min_sum;
  logic [5:0] next_min;
  logic [4:0] next_hours;

  always_comb begin
    match_alarm  = (hours == alarm_hours) && (minutes == alarm_minutes) && (seconds == 6'd0);
    match_snooze = (hours == tgt_hours_q) && (minutes == tgt_min_q) && (seconds == 6'd0);
    timeout      = (state_q == S_RINGING) && (pre_q == PRE_LAST) &&
                   (ms_q == 10'd999) && (sec_q == SEC_LAST);
  end

  // Snooze target: current time plus SNOOZE_MIN with minute/hour wrap.
  always_comb begin
    min_sum    = {1'b0, minutes} + 7'(SNOOZE_MIN);
    next_min   = min_sum[5:0];
    next_hours = hours;
    if (min_sum >= 7'd60) begin
      next_min   = 6'(min_sum - 7'd60);
      next_hours = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_hours_d = tgt_hours_q;
    tgt_min_d   = tgt_min_q;
    if (!armed) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (alarm_edge_q) begin
            state_d = S_RINGING;
            cnt_d   = '0;
          end
        end
        S_RINGING: begin
          if (dismiss || timeout) begin
            state_d = S_IDLE;
          end else if (snooze && (cnt_q < CNT_MAX)) begin
            state_d     = S_SNOOZE;
            tgt_hours_d = next_hours;
            tgt_min_d   = next_min;
            cnt_d       = cnt_q + 1'b1;
          end
        end
        S_SNOOZE: begin
          if (dismiss) begin
            state_d = S_IDLE;
          end else if (snz_edge_q) begin
            state_d = S_RINGING;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Timeout chain advances only while staying in RINGING; any entry restarts it.
  always_comb begin
    pre_d = '0;
    ms_d  = '0;
    sec_d = '0;
    if ((state_q == S_RINGING) && (state_d == S_RINGING)) begin
      pre_d = pre_q;
      ms_d  = ms_q;
      sec_d = sec_q;
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (ms_q == 10'd999) begin
          ms_d  = '0;
          sec_d = sec_q + 1'b1;
        end else begin
          ms_d = ms_q + 10'd1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_comb begin
`ifdef ALARM_BUZZER_PULSE_EN
    buzzer_d = (state_d == S_RINGING) && (ms_d < 10'd500);
`else
    buzzer_d = (state_d == S_RINGING);
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tgt_hours_q   <= '0;
      tgt_min_q     <= '0;
      pre_q         <= '0;
      ms_q          <= '0;
      sec_q         <= '0;
      alarm_match_q <= 1'b0;
      alarm_edge_q  <= 1'b0;
      snz_match_q   <= 1'b0;
      snz_edge_q    <= 1'b0;
      ring_q        <= 1'b0;
      snz_q         <= 1'b0;
      buzzer_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tgt_hours_q   <= tgt_hours_d;
      tgt_min_q     <= tgt_min_d;
      pre_q         <= pre_d;
      ms_q          <= ms_d;
      sec_q         <= sec_d;
      alarm_match_q <= match_alarm;
      alarm_edge_q  <= match_alarm & ~alarm_match_q;
      snz_match_q   <= match_snooze;
      snz_edge_q    <= match_snooze & ~snz_match_q;
      ring_q        <= (state_d == S_RINGING);
      snz_q         <= (state_d == S_SNOOZE);
      buzzer_q      <= buzzer_d;
    end
  end

  assign ringing  = ring_q;
  assign blink_en = ring_q;
  assign snoozing = snz_q;
  assign buzzer   = buzzer_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
// ============================================================================
// tb_alarm_sequencer : directed self-checking bench for alarm_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alarm_sequencer;

  logic       clock = 1'b0;
  logic       reset_n, armed, snooze, dismiss;
  logic [4:0] hours, alarm_hours;
  logic [5:0] minutes, seconds, alarm_minutes;
  logic       blink_en, buzzer, ringing, snoozing;
  logic [3:0] outs;
  int         checks = 0;
  int         errors = 0;

  // {ringing, snoozing, blink_en, buzzer}
  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_RING = 4'b1011;
  localparam logic [3:0] O_SNZ  = 4'b0100;

  assign outs = {ringing, snoozing, blink_en, buzzer};

  always #5 clock = ~clock;

  alarm_sequencer #(
    .CLOCK_FREQ_1KHZ(2),
    .SNOOZE_MIN     (5),
    .RING_TIMEOUT_S (3),
    .MAX_SNOOZE     (2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .armed        (armed),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds),
    .alarm_hours  (alarm_hours),
    .alarm_minutes(alarm_minutes),
    .snooze       (snooze),
    .dismiss      (dismiss),
    .blink_en     (blink_en),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozing     (snoozing)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    hours   = h;
    minutes = m;
    seconds = s;
  endtask

  // Program alarm h:m, step time from h:m:01 to h:m:00, wait the two-edge latency.
  task automatic trigger(input logic [4:0] h, input logic [5:0] m);
    alarm_hours   = h;
    alarm_minutes = m;
    set_time(h, m, 6'd1);
    tick();
    seconds = 6'd0;
    tick();
    tick();
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
  endtask

  task automatic pulse_dismiss();
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    armed = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    alarm_hours = 5'd0; alarm_minutes = 6'd0;
    set_time(5'd0, 6'd0, 6'd0);
    tick(); tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL reset_in: got %b want %b", outs, O_IDLE);
    end
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL reset_out: got %b want %b", outs, O_IDLE);
    end
  endtask

  task automatic test_trigger();
    armed = 1'b1;
    alarm_hours = 5'd7; alarm_minutes = 6'd30;
    set_time(5'd7, 6'd29, 6'd59);
    tick(); tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL trig_before: got %b want %b", outs, O_IDLE);
    end
    set_time(5'd7, 6'd30, 6'd0);
    tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL trig_latency: got %b want %b", outs, O_IDLE);
    end
    tick();
    checks++;
    if (outs !== O_RING) begin
      errors++; $display("FAIL trig_ring: got %b want %b", outs, O_RING);
    end
    pulse_dismiss();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL trig_dismiss: got %b want %b", outs, O_IDLE);
    end
    repeat (5) tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL trig_no_retrigger: got %b want %b", outs, O_IDLE);
    end
  endtask

  task automatic test_snooze_wrap();
    trigger(5'd23, 6'd58);
    checks++;
    if (outs !== O_RING) begin
      errors++; $display("FAIL wrap_ring: got %b want %b", outs, O_RING);
    end
    pulse_snooze();
    checks++;
    if (outs !== O_SNZ) begin
      errors++; $display("FAIL wrap_snooze: got %b want %b", outs, O_SNZ);
    end
    set_time(5'd0, 6'd2, 6'd59);
    repeat (3) tick();
    checks++;
    if (outs !== O_SNZ) begin
      errors++; $display("FAIL wrap_early: got %b want %b", outs, O_SNZ);
    end
    set_time(5'd0, 6'd3, 6'd0);
    tick();
    checks++;
    if (outs !== O_SNZ) begin
      errors++; $display("FAIL wrap_latency: got %b want %b", outs, O_SNZ);
    end
    tick();
    checks++;
    if (outs !== O_RING) begin
      errors++; $display("FAIL wrap_rering: got %b want %b", outs, O_RING);
    end
    pulse_dismiss();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL wrap_dismiss: got %b want %b", outs, O_IDLE);
    end
  endtask

  task automatic test_snooze_limit();
    trigger(5'd6, 6'd0);
    pulse_snooze();
    checks++;
    if (outs !== O_SNZ) begin
      errors++; $display("FAIL limit_snz1: got %b want %b", outs, O_SNZ);
    end
    set_time(5'd6, 6'd5, 6'd0);
    tick(); tick();
    checks++;
    if (outs !== O_RING) begin
      errors++; $display("FAIL limit_ring1: got %b want %b", outs, O_RING);
    end
    pulse_snooze();
    checks++;
    if (outs !== O_SNZ) begin
      errors++; $display("FAIL limit_snz2: got %b want %b", outs, O_SNZ);
    end
    pulse_snooze();
    checks++;
    if (outs !== O_SNZ) begin
      errors++; $display("FAIL limit_snz_ignored: got %b want %b", outs, O_SNZ);
    end
    set_time(5'd6, 6'd10, 6'd0);
    tick(); tick();
    checks++;
    if (outs !== O_RING) begin
      errors++; $display("FAIL limit_ring2: got %b want %b", outs, O_RING);
    end
    pulse_snooze();
    checks++;
    if (outs !== O_RING) begin
      errors++; $display("FAIL limit_third: got %b want %b", outs, O_RING);
    end
    pulse_dismiss();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL limit_dismiss: got %b want %b", outs, O_IDLE);
    end
  endtask

  task automatic test_timeout();
    logic early;
    logic buz_mid;
    logic buz_exp;
    early   = 1'b0;
    buz_mid = 1'b0;
`ifdef ALARM_BUZZER_PULSE_EN
    buz_exp = 1'b0;
`else
    buz_exp = 1'b1;
`endif
    trigger(5'd8, 6'd0);
    checks++;
    if (outs !== O_RING) begin
      errors++; $display("FAIL tmo_ring: got %b want %b", outs, O_RING);
    end
    for (int i = 1; i < 6000; i++) begin
      tick();
      if (ringing !== 1'b1) early = 1'b1;
      if (i == 1500) buz_mid = buzzer;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL tmo_early: got %b want 0", early);
    end
    checks++;
    if (buz_mid !== buz_exp) begin
      errors++; $display("FAIL tmo_buzzer_750ms: got %b want %b", buz_mid, buz_exp);
    end
    tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL tmo_expire: got %b want %b", outs, O_IDLE);
    end
  endtask

  task automatic test_simultaneous();
    trigger(5'd10, 6'd20);
    snooze  = 1'b1;
    dismiss = 1'b1;
    tick();
    snooze  = 1'b0;
    dismiss = 1'b0;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL simul_both: got %b want %b", outs, O_IDLE);
    end
    pulse_snooze();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL simul_idle_snooze: got %b want %b", outs, O_IDLE);
    end
    trigger(5'd10, 6'd40);
    pulse_snooze();
    checks++;
    if (outs !== O_SNZ) begin
      errors++; $display("FAIL simul_snz: got %b want %b", outs, O_SNZ);
    end
    armed = 1'b0;
    tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL simul_disarm: got %b want %b", outs, O_IDLE);
    end
    armed = 1'b1;
  endtask

  task automatic test_reset_mid_ring();
    trigger(5'd9, 6'd15);
    checks++;
    if (outs !== O_RING) begin
      errors++; $display("FAIL rst_ring: got %b want %b", outs, O_RING);
    end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    armed   = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL rst_async: got %b want %b", outs, O_IDLE);
    end
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL rst_release: got %b want %b", outs, O_IDLE);
    end
    armed = 1'b1;
    trigger(5'd11, 6'd0);
    pulse_snooze();
    set_time(5'd11, 6'd5, 6'd0);
    tick(); tick();
    pulse_snooze();
    checks++;
    if (outs !== O_SNZ) begin
      errors++; $display("FAIL rst_count_cleared: got %b want %b", outs, O_SNZ);
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_snooze_wrap();
    test_snooze_limit();
    test_timeout();
    test_simultaneous();
    test_reset_mid_ring();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/alarm_sequencer.md
# alarm_sequencer

Alarm state controller for the alarm clock. Compares the running time against the stored alarm time and sequences the ring/snooze/dismiss cycle. Drives the `enable` input of the display Blinker and the buzzer. Sits between the timekeeping counters and the display/buzzer outputs.

## Interface
- `CLOCK_FREQ_1KHZ`, default 50000: clock cycles per 1 ms tick.
- `SNOOZE_MIN`, default 5: snooze length in minutes, 1..59.
- `RING_TIMEOUT_S`, default 60: seconds of unattended ringing before auto-dismiss, at least 1.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event; later snooze pulses are ignored.

Ports:
- `clock` in 1: system clock. One clock domain only.
- `reset_n` in 1: asynchronous, active-low reset.
- `armed` in 1: alarm enabled (level).
- `hours` in 5: current hour, binary, 0..23.
- `minutes` in 6: current minute, binary, 0..59.
- `seconds` in 6: current second, binary, 0..59.
- `alarm_hours` in 5: alarm hour, 0..23.
- `alarm_minutes` in 6: alarm minute, 0..59.
- `snooze` in 1: single-cycle pulse, debounced upstream.
- `dismiss` in 1: single-cycle pulse, debounced upstream.
- `blink_en` out 1: Blinker enable; high in RINGING.
- `buzzer` out 1: buzzer drive.
- `ringing` out 1: state == RINGING.
- `snoozing` out 1: state == SNOOZE.

## Operation
- States: IDLE, RINGING, SNOOZE. Reset puts the block in IDLE.
- `match_alarm` = (`hours`,`minutes`) == (`alarm_hours`,`alarm_minutes`) and `seconds` == 0.
- `match_snooze` = (`hours`,`minutes`) == snooze target and `seconds` == 0.
- Each match is registered once. A trigger is its rising edge only (match high, registered copy low). Any match already high while the time stays unchanged never retriggers.

Transitions:
- IDLE -> RINGING: `armed` and a `match_alarm` edge. Clear snooze count and timeout counters.
- RINGING -> SNOOZE: `snooze` pulse with snooze count < `MAX_SNOOZE`. Load target = current time + `SNOOZE_MIN` minutes. Minute wraps 59 -> 0 with hour carry; hour wraps 23 -> 0. Increment snooze count.
- RINGING -> IDLE: `dismiss` pulse, or timeout reaches `RING_TIMEOUT_S`.
- SNOOZE -> RINGING: `match_snooze` edge. Clear timeout counters.
- SNOOZE -> IDLE: `dismiss` pulse.
- Any state -> IDLE: `armed` low. This has top priority.

Priority and edge cases:
- Priority order: `armed` low > `dismiss` > timeout > `snooze`.
- In IDLE, `snooze` and `dismiss` are ignored. In SNOOZE, `snooze` is ignored.
- Timeout counting: 1 ms prescaler 0..`CLOCK_FREQ_1KHZ`-1, then ms counter 0..999, then seconds counter. These run only in RINGING and are zeroed on every entry to RINGING.

## Timing
- All outputs are registered.
- Reset values: `blink_en`=0, `buzzer`=0, `ringing`=0, `snoozing`=0. Internal counters and snooze target are 0; registered matches are 0.
- Trigger latency:
  - Time inputs are sampled at edge N. The registered match updates at N. The state changes at N+1. Outputs reflect the new state at N+1.
  - `snooze` or `dismiss` sampled at edge N: state and outputs change at N.
- Timeout fires on the cycle the seconds counter would reach `RING_TIMEOUT_S`: `RING_TIMEOUT_S`*1000*`CLOCK_FREQ_1KHZ` cycles after entering RINGING.
- `reset_n` low mid-ring: outputs drop to 0 asynchronously, with no wait for a clock edge.

## Configuration
- Macro `ALARM_BUZZER_PULSE_EN`.
- Defined: in RINGING, `buzzer` toggles every 500 ms, reusing the ms counter. It starts high on RINGING entry.
- Undefined: `buzzer` is steady high throughout RINGING.
- In both cases `buzzer` is 0 outside RINGING.

## Test plan
Bench settings: `CLOCK_FREQ_1KHZ`=2, `RING_TIMEOUT_S`=3, `SNOOZE_MIN`=5, `MAX_SNOOZE`=2.
- Trigger: alarm 07:30, `armed`=1, time steps to 07:30:00 -> `ringing`=1 and `blink_en`=1 one cycle after the match edge. Holding 07:30:00 after `dismiss` does not retrigger.
- Snooze wrap: ringing at 23:58, `snooze` pulse -> `snoozing`=1. Time 00:03:00 -> `ringing`=1. Time 00:02:59 -> no trigger.
- Snooze limit: two snooze cycles complete; a third `snooze` while ringing -> stays RINGING.
- Timeout: ringing with no input -> IDLE after exactly 6000 cycles; `buzzer`=0 and `blink_en`=0.
- Simultaneous inputs: `snooze` and `dismiss` in the same cycle -> IDLE. `armed`=0 mid-SNOOZE -> IDLE next edge.
- Reset mid-ring: `reset_n`=0 -> all outputs 0 immediately. After release, IDLE with snooze count 0.
